// File: rtl/fetch_unit.sv
// Instruction fetch with a DEPTH-entry prefetch queue. A redirect flushes the queue and drops any in-flight responses.
// Optional macro FETCH_UNIT_BYPASS_EN lets a response reach decode in the cycle it arrives; without it instr_valid rises one cycle later.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   dat_q [DEPTH];
  logic [31:0]   pc_q  [DEPTH];

  logic [CW:0]   inflight;
  logic [31:0]   redirect_tgt;
  logic          accept, resp_drop, resp_keep, push, pop, q_vld, bypass_take;

  // Queued words plus outstanding requests never exceed DEPTH, so a response always has a slot.
  assign inflight         = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid_o = rst_ni && !redirect_valid_i && (inflight < DEPTH_W);
  assign imem_req_addr_o  = fetch_pc_q;
  assign redirect_tgt     = redirect_pc_i & ~32'h3;

  assign accept    = imem_req_valid_o && imem_req_ready_i;
  assign resp_drop = imem_resp_valid_i && (drop_q != '0);
  assign resp_keep = imem_resp_valid_i && (drop_q == '0) && !redirect_valid_i;
  assign q_vld     = (count_q != '0);

`ifdef FETCH_UNIT_BYPASS_EN
  logic bypass;
  assign bypass        = resp_keep && !q_vld;
  assign bypass_take   = bypass && instr_ready_i;
  assign instr_valid_o = q_vld || bypass;
  assign instr_o       = q_vld ? dat_q[rd_ptr_q] : (bypass ? imem_resp_data_i : '0);
  assign instr_pc_o    = q_vld ? pc_q[rd_ptr_q]  : (bypass ? resp_pc_q : '0);
`else
  assign bypass_take   = 1'b0;
  assign instr_valid_o = q_vld;
  assign instr_o       = q_vld ? dat_q[rd_ptr_q] : '0;
  assign instr_pc_o    = q_vld ? pc_q[rd_ptr_q]  : '0;
`endif

  assign push = resp_keep && !bypass_take;
  assign pop  = q_vld && instr_ready_i && !redirect_valid_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q + CW'(accept) - CW'(imem_resp_valid_i);
    if (redirect_valid_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      drop_d     = outst_q - CW'(imem_resp_valid_i);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (accept)    fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_drop) drop_d     = drop_q - CW'(1);
      if (resp_keep) resp_pc_d  = resp_pc_q + 32'd4;
      if (push)      wr_ptr_d   = wr_ptr_q + AW'(1);
      if (pop)       rd_ptr_d   = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      drop_q     <= '0;
      outst_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      drop_q     <= drop_d;
      outst_q    <= outst_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: outputs are masked to zero whenever the queue is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      dat_q[wr_ptr_q] <= imem_resp_data_i;
      pc_q[wr_ptr_q]  <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model answers accepted requests, a monitor pops an expected-PC queue on every decode handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

`ifdef FETCH_UNIT_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (imem_req_addr),
    .imem_resp_valid_i(imem_resp_valid),
    .imem_resp_data_i (imem_resp_data),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .instr_o          (instr),
    .instr_pc_o       (instr_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          budget_lim = 0;
  int          n_acc = 0;
  bit          resp_en = 1'b1;
  int          first_resp_cyc = -1;
  pend_t       pend[$];
  logic [31:0] exp_q[$];
  int          pop_cyc[$];
  logic [31:0] mon_e;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: responds in order, earliest one cycle after acceptance, and forgets everything on reset.
  always @(negedge clk) begin
    #1;
    if (!rst_n) pend.delete();
    if (rst_n && resp_en && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word_at(pend[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    imem_req_ready = (n_acc < budget_lim);
    #1;
    if (imem_resp_valid) begin
      void'(pend.pop_front());
      if (first_resp_cyc < 0) first_resp_cyc = cyc;
    end
    if (imem_req_valid && imem_req_ready) begin
      n_acc++;
      pend.push_back('{addr: imem_req_addr, due: cyc + 1});
    end
  end

  always @(negedge clk) begin
    #3;
    if (rst_n && !redirect_valid && instr_valid && instr_ready) begin
      pop_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: got pc %h data %h, no instruction expected", instr_pc, instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (instr_pc !== mon_e || instr !== word_at(mon_e)) begin
          errors++;
          $display("FAIL instr_order: got pc %h data %h, expected pc %h data %h",
                   instr_pc, instr, mon_e, word_at(mon_e));
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic allow(input int k);
    budget_lim = n_acc + k;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string nm, input int lim);
    int i = 0;
    while (exp_q.size() != 0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    #4;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d expected words never seen", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_acc(input string nm, input int lim);
    int i = 0;
    while (n_acc < budget_lim && i < lim) begin
      @(negedge clk);
      #3;
      i++;
    end
    if (n_acc < budget_lim) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d accepts, required %0d", nm, n_acc, budget_lim);
      budget_lim = n_acc;
    end
  endtask

  initial begin
    bit stable;
    int a0;

    // Reset state
    tick(2);
    #3;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);

    // Streaming fetch, one instruction per cycle
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    pop_cyc.delete();
    first_resp_cyc = -1;
    allow(4);
    instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    wait_drain("stream", 40);
    chk("stream_pops", 32'(pop_cyc.size()), 32'd4);
    if (pop_cyc.size() == 4) begin
      chk("stream_back_to_back", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
      chk("resp_to_instr_latency", 32'(pop_cyc[0] - first_resp_cyc), 32'(LAT));
    end

    // Decode stalled: exactly DEPTH requests, head held stable
    instr_ready = 1'b0;
    do_reset();
    a0 = n_acc;
    allow(100);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      #3;
      if (instr_valid && (instr_pc !== 32'h0 || instr !== word_at(32'h0))) stable = 1'b0;
    end
    chk("stall_head_stable", 32'(stable), 32'd1);
    chk("stall_instr_valid", 32'(instr_valid), 32'd1);
    chk("stall_accepts", 32'(n_acc - a0), 32'd4);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    budget_lim = n_acc;
    instr_ready = 1'b1;
    wait_drain("stall_drain", 40);

    // Redirect with 0x8 and 0xC outstanding
    do_reset();
    exp_q = '{32'h0, 32'h4};
    allow(2);
    wait_drain("pre_redirect", 40);
    resp_en = 1'b0;
    allow(2);
    wait_acc("redirect_setup", 20);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    allow(2);
    exp_q = '{32'h100, 32'h104};
    #3;
    chk("redirect_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    resp_en = 1'b1;
    #3;
    chk("redirect_flush", 32'(instr_valid), 32'd0);
    chk("redirect_addr", imem_req_addr, 32'h100);
    wait_drain("redirect", 40);

    // Back-to-back redirects, one stale response landing in the second
    resp_en = 1'b0;
    allow(2);
    wait_acc("b2b_setup", 20);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_pc = 32'h301;
    resp_en = 1'b1;
    allow(2);
    exp_q = '{32'h300, 32'h304};
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    chk("b2b_addr", imem_req_addr, 32'h300);
    wait_drain("b2b_redirect", 40);

    // Queue near full: simultaneous push and pop keep order
    instr_ready = 1'b0;
    do_reset();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    allow(3);
    wait_acc("full_setup", 20);
    tick(3);
    resp_en = 1'b0;
    allow(1);
    wait_acc("full_last", 20);
    @(negedge clk);
    #3;
    chk("full_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    instr_ready = 1'b1;
    resp_en = 1'b1;
    wait_drain("full_push_pop", 40);

    // Asynchronous reset with three words queued
    instr_ready = 1'b0;
    allow(3);
    wait_acc("midrst_setup", 20);
    tick(3);
    chk("midrst_queued", 32'(instr_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr_pc", instr_pc, 32'h0);
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = '{32'h0};
    allow(1);
    instr_ready = 1'b1;
    #3;
    chk("postrst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("postrst_req_addr", imem_req_addr, 32'h0);
    wait_drain("postrst", 40);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
